// File: rtl/eproc_in_frame_assembler.sv
// eproc_in_frame_assembler
//   Takes decoded 8b10b characters from the e-link decoder and packs SOP / data / EOP
//   character streams into 10-bit flagged words for the RX FIFO. It enforces frame
//   structure: a maximum frame length, an inter-character timeout, and frames dropped
//   at SOP when the FIFO is nearly full. It also keeps saturating status counters.
//
// Ports
//   bitCLKx4    in   sole clock, rising edge
//   rst         in   asynchronous active-high reset
//   HGFEDCBA    in   [7:0] decoded byte
//   ISK         in   [1:0] 00 data, 10 SOP, 01 EOP, 11 comma/idle
//   DATA_RDY    in   one-cycle strobe qualifying HGFEDCBA/ISK (at least 2 cycles apart)
//   fifo_pfull  in   RX FIFO programmable-full, looked at only when a frame starts
//   fifo_din    out  [9:0] {flag, byte}: 10 SOP, 00 data, 01 EOP, 11 error
//   fifo_wr_en  out  one-cycle write strobe for fifo_din
//   busy        out  high whenever a frame is open or being discarded
//   frame_cnt   out  [CNT_W-1:0] good frames closed with EOP
//   err_cnt     out  [CNT_W-1:0] protocol errors
//   drop_cnt    out  [CNT_W-1:0] frames refused at SOP because of fifo_pfull
module eproc_in_frame_assembler #(
  parameter int MAX_LEN = 256,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic             bitCLKx4,
  input  logic             rst,
  input  logic [7:0]       HGFEDCBA,
  input  logic [1:0]       ISK,
  input  logic             DATA_RDY,
  input  logic             fifo_pfull,
  output logic [9:0]       fifo_din,
  output logic             fifo_wr_en,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic [1:0] ISK_DATA  = 2'b00;
  localparam logic [1:0] ISK_EOP   = 2'b01;
  localparam logic [1:0] ISK_SOP   = 2'b10;
  localparam logic [1:0] ISK_COMMA = 2'b11;

  localparam logic [1:0] FLAG_DATA = 2'b00;
  localparam logic [9:0] WORD_SOP  = 10'h200;
  localparam logic [9:0] WORD_EOP  = 10'h100;
  localparam logic [9:0] WORD_E1   = 10'h3E1;  // frame longer than MAX_LEN
  localparam logic [9:0] WORD_E2   = 10'h3E2;  // SOP inside an open frame
  localparam logic [9:0] WORD_E3   = 10'h3E3;  // inter-character timeout

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FRAME = 2'b01,
    ST_DROP  = 2'b10
  } state_t;

  state_t           state_q,     state_d;
  logic [LEN_W-1:0] len_q,       len_d;
  logic [TMR_W-1:0] timer_q,     timer_d;
  logic             sop_pend_q,  sop_pend_d;
  logic [9:0]       fifo_din_q,  fifo_din_d;
  logic             fifo_wr_q,   fifo_wr_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q,  drop_cnt_d;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    timer_d     = timer_q;
    sop_pend_d  = 1'b0;
    fifo_din_d  = fifo_din_q;
    fifo_wr_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    case (state_q)
      ST_IDLE, ST_DROP: begin
        timer_d = '0;
        if (DATA_RDY) begin
          case (ISK)
            ISK_SOP: begin
              // The FIFO headroom decision is made once per frame, here.
              if (fifo_pfull) begin
                drop_cnt_d = sat_inc(drop_cnt_q);
                state_d    = ST_DROP;
              end else begin
                fifo_din_d = WORD_SOP;
                fifo_wr_d  = 1'b1;
                len_d      = '0;
                state_d    = ST_FRAME;
              end
            end
            ISK_EOP: begin
              if (state_q == ST_IDLE) err_cnt_d = sat_inc(err_cnt_q);
              else                    state_d   = ST_IDLE;
            end
            ISK_DATA: begin
              // Stray data outside a frame is an error; inside a dropped frame it is expected.
              if (state_q == ST_IDLE) err_cnt_d = sat_inc(err_cnt_q);
            end
            ISK_COMMA: ;
            default: ;
          endcase
        end
      end

      ST_FRAME: begin
        if (sop_pend_q) begin
          // Second half of a SOP-inside-frame: the error word went out last cycle,
          // now open the new frame. DATA_RDY spacing keeps this slot free of characters.
          timer_d = timer_q + 1'b1;
          if (fifo_pfull) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
            state_d    = ST_DROP;
          end else begin
            fifo_din_d = WORD_SOP;
            fifo_wr_d  = 1'b1;
            len_d      = '0;
          end
        end else if (DATA_RDY) begin
          // A character arriving on the expiry cycle wins over the timeout.
          timer_d = '0;
          case (ISK)
            ISK_DATA: begin
              fifo_wr_d = 1'b1;
              if (len_q == LEN_MAX) begin
                fifo_din_d = WORD_E1;
                err_cnt_d  = sat_inc(err_cnt_q);
                state_d    = ST_DROP;
              end else begin
                fifo_din_d = {FLAG_DATA, HGFEDCBA};
                len_d      = len_q + 1'b1;
              end
            end
            ISK_EOP: begin
              fifo_din_d  = WORD_EOP;
              fifo_wr_d   = 1'b1;
              frame_cnt_d = sat_inc(frame_cnt_q);
              state_d     = ST_IDLE;
            end
            ISK_SOP: begin
              fifo_din_d = WORD_E2;
              fifo_wr_d  = 1'b1;
              err_cnt_d  = sat_inc(err_cnt_q);
              sop_pend_d = 1'b1;
            end
            ISK_COMMA: ;
            default: ;
          endcase
        end else if (timer_q == TMR_LAST) begin
          fifo_din_d = WORD_E3;
          fifo_wr_d  = 1'b1;
          err_cnt_d  = sat_inc(err_cnt_q);
          timer_d    = '0;
          state_d    = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge bitCLKx4 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      timer_q     <= '0;
      sop_pend_q  <= 1'b0;
      fifo_din_q  <= '0;
      fifo_wr_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      timer_q     <= timer_d;
      sop_pend_q  <= sop_pend_d;
      fifo_din_q  <= fifo_din_d;
      fifo_wr_q   <= fifo_wr_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign fifo_din   = fifo_din_q;
  assign fifo_wr_en = fifo_wr_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_eproc_in_frame_assembler.sv
// Bench for eproc_in_frame_assembler: directed character streams, a character-level
// reference model producing expected FIFO words (with the cycle each must appear in)
// and expected counters, and literal expectations per scenario.
module tb_eproc_in_frame_assembler;

  localparam int MAX_LEN = 256;
  localparam int TIMEOUT = 4096;
  localparam int CNT_W   = 4;

  localparam int M_IDLE  = 0;
  localparam int M_FRAME = 1;
  localparam int M_DROP  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       HGFEDCBA = 8'h00;
  logic [1:0]       ISK = 2'b00;
  logic             DATA_RDY = 1'b0;
  logic             fifo_pfull = 1'b0;
  logic [9:0]       fifo_din;
  logic             fifo_wr_en;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] drop_cnt;

  eproc_in_frame_assembler #(
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .bitCLKx4   (clk),
    .rst        (rst),
    .HGFEDCBA   (HGFEDCBA),
    .ISK        (ISK),
    .DATA_RDY   (DATA_RDY),
    .fifo_pfull (fifo_pfull),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] w;
    int         c;
  } exp_t;

  exp_t       expq[$];
  logic [9:0] got[$];
  logic [9:0] ew[$];

  int m_st = M_IDLE;
  int m_len = 0;
  int m_last = 0;
  int m_pend_drop = -1;
  int m_frame = 0;
  int m_err = 0;
  int m_drop = 0;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int msat(int v);
    return (v >= (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  function automatic void push(logic [9:0] w, int c);
    exp_t e;
    e.w = w;
    e.c = c;
    expq.push_back(e);
  endfunction

  // Character-level reference: what one received character must produce.
  // t is the cycle whose rising edge samples the character.
  function automatic void model_char(logic [1:0] isk, logic [7:0] b);
    int t;
    t = cyc + 1;
    if (m_st == M_FRAME) begin
      m_last = t;
      case (isk)
        2'b00: begin
          if (m_len < MAX_LEN) begin
            push({2'b00, b}, t);
            m_len++;
          end else begin
            push(10'h3E1, t);
            m_err = msat(m_err);
            m_st  = M_DROP;
          end
        end
        2'b01: begin
          push(10'h100, t);
          m_frame = msat(m_frame);
          m_st    = M_IDLE;
        end
        2'b10: begin
          push(10'h3E2, t);
          m_err = msat(m_err);
          if (fifo_pfull) begin
            m_pend_drop = t + 1;
            m_st        = M_DROP;
          end else begin
            push(10'h200, t + 1);
            m_len = 0;
          end
        end
        default: ;
      endcase
    end else begin
      case (isk)
        2'b10: begin
          if (fifo_pfull) begin
            m_drop = msat(m_drop);
            m_st   = M_DROP;
          end else begin
            push(10'h200, t);
            m_len  = 0;
            m_last = t;
            m_st   = M_FRAME;
          end
        end
        2'b01: begin
          if (m_st == M_IDLE) m_err = msat(m_err);
          else                m_st  = M_IDLE;
        end
        2'b00: begin
          if (m_st == M_IDLE) m_err = msat(m_err);
        end
        default: ;
      endcase
    end
  endfunction

  function automatic void model_reset();
    m_st = M_IDLE;
    m_len = 0;
    m_last = 0;
    m_pend_drop = -1;
    m_frame = 0;
    m_err = 0;
    m_drop = 0;
    expq.delete();
  endfunction

  // Per-cycle compare, sampled 2 time units after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        if (m_pend_drop == cyc) begin
          m_drop      = msat(m_drop);
          m_pend_drop = -1;
        end
        if (m_st == M_FRAME && cyc == m_last + TIMEOUT) begin
          push(10'h3E3, cyc);
          m_err = msat(m_err);
          m_st  = M_IDLE;
        end
        if (fifo_wr_en) begin
          got.push_back(fifo_din);
          if (expq.size() == 0) begin
            chk("spurious_wr_en", {31'd0, fifo_wr_en}, 32'd0);
          end else begin
            e = expq.pop_front();
            chk("fifo_din", {22'd0, fifo_din}, {22'd0, e.w});
            chk("write_cycle", cyc, e.c);
          end
        end else if (expq.size() > 0 && expq[0].c <= cyc) begin
          e = expq.pop_front();
          chk("missing_wr_en", {31'd0, fifo_wr_en}, 32'd1);
        end
        chk("frame_cnt", {28'd0, frame_cnt}, m_frame);
        chk("err_cnt",   {28'd0, err_cnt},   m_err);
        chk("drop_cnt",  {28'd0, drop_cnt},  m_drop);
        chk("busy",      {31'd0, busy},      (m_st != M_IDLE) ? 32'd1 : 32'd0);
      end
    end
  end

  task automatic send(input logic [1:0] isk, input logic [7:0] b);
    @(negedge clk);
    model_char(isk, b);
    DATA_RDY = 1'b1;
    ISK      = isk;
    HGFEDCBA = b;
    @(negedge clk);
    DATA_RDY = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    chk("words_outstanding", expq.size(), 0);
  endtask

  task automatic chk_words(string name);
    chk({name, "_count"}, got.size(), ew.size());
    for (int i = 0; i < ew.size() && i < got.size(); i++)
      chk(name, {22'd0, got[i]}, {22'd0, ew[i]});
  endtask

  task automatic chk_cnts(int f, int e, int d, int b);
    chk("lit_frame_cnt", {28'd0, frame_cnt}, f);
    chk("lit_err_cnt",   {28'd0, err_cnt},   e);
    chk("lit_drop_cnt",  {28'd0, drop_cnt},  d);
    chk("lit_busy",      {31'd0, busy},      b);
  endtask

  initial begin
    // Reset state
    idle(3);
    chk("rst_fifo_din", {22'd0, fifo_din}, 32'd0);
    chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk_cnts(0, 0, 0, 0);
    rst = 1'b0;
    idle(2);

    // Basic frame
    got.delete();
    send(2'b10, 8'h00);
    send(2'b00, 8'h11);
    send(2'b00, 8'h22);
    send(2'b00, 8'h33);
    send(2'b01, 8'h00);
    settle();
    ew = {10'h200, 10'h011, 10'h022, 10'h033, 10'h100};
    chk_words("basic_words");
    chk_cnts(1, 0, 0, 0);

    // Over-length frame: MAX_LEN+1 data bytes
    got.delete();
    send(2'b10, 8'h00);
    for (int i = 0; i <= MAX_LEN; i++) send(2'b00, i[7:0]);
    chk("long_busy_in_drop", {31'd0, busy}, 32'd1);
    send(2'b01, 8'h00);
    settle();
    chk("long_count", got.size(), MAX_LEN + 2);
    chk("long_first", {22'd0, got[0]}, 32'h200);
    chk("long_last_data", {22'd0, got[MAX_LEN]}, 32'h0FF);
    chk("long_err_word", {22'd0, got[MAX_LEN + 1]}, 32'h3E1);
    chk_cnts(1, 1, 0, 0);

    // Frame refused at SOP, then a normal frame with pfull rising mid-frame
    got.delete();
    fifo_pfull = 1'b1;
    send(2'b10, 8'h00);
    send(2'b00, 8'h55);
    send(2'b01, 8'h00);
    settle();
    chk("drop_count", got.size(), 0);
    chk_cnts(1, 1, 1, 0);
    fifo_pfull = 1'b0;
    send(2'b10, 8'h00);
    fifo_pfull = 1'b1;
    send(2'b00, 8'h66);
    send(2'b01, 8'h00);
    fifo_pfull = 1'b0;
    settle();
    ew = {10'h200, 10'h066, 10'h100};
    chk_words("after_drop_words");
    chk_cnts(2, 1, 1, 0);

    // SOP inside a frame restarts it
    got.delete();
    send(2'b10, 8'h00);
    send(2'b00, 8'hAA);
    send(2'b10, 8'h00);
    send(2'b00, 8'hBB);
    send(2'b01, 8'h00);
    settle();
    ew = {10'h200, 10'h0AA, 10'h3E2, 10'h200, 10'h0BB, 10'h100};
    chk_words("sop_sop_words");
    chk_cnts(3, 2, 1, 0);

    // SOP inside a frame while pfull: restart refused, rest discarded
    got.delete();
    send(2'b10, 8'h00);
    send(2'b00, 8'h12);
    fifo_pfull = 1'b1;
    send(2'b10, 8'h00);
    send(2'b00, 8'h34);
    send(2'b01, 8'h00);
    fifo_pfull = 1'b0;
    settle();
    ew = {10'h200, 10'h012, 10'h3E2};
    chk_words("sop_pfull_words");
    chk_cnts(3, 3, 2, 0);

    // Commas: ignored in IDLE; in a frame they hold off the timeout, even on the expiry cycle
    got.delete();
    send(2'b11, 8'hBC);
    send(2'b10, 8'h00);
    send(2'b00, 8'h01);
    idle(TIMEOUT - 2);
    send(2'b11, 8'hBC);
    idle(TIMEOUT - 2);
    send(2'b00, 8'h02);
    send(2'b01, 8'h00);
    settle();
    ew = {10'h200, 10'h001, 10'h002, 10'h100};
    chk_words("race_words");
    chk_cnts(4, 3, 2, 0);

    // Inter-character timeout
    got.delete();
    send(2'b10, 8'h00);
    send(2'b00, 8'h77);
    idle(TIMEOUT + 5);
    settle();
    ew = {10'h200, 10'h077, 10'h3E3};
    chk_words("timeout_words");
    chk_cnts(4, 4, 2, 0);

    // Stray data in IDLE saturates err_cnt
    got.delete();
    for (int i = 0; i < 14; i++) send(2'b00, 8'hC0);
    settle();
    chk("sat_count", got.size(), 0);
    chk_cnts(4, 15, 2, 0);

    // Reset mid-frame
    send(2'b10, 8'h00);
    send(2'b00, 8'h01);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_fifo_din", {22'd0, fifo_din}, 32'd0);
    chk("midrst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk_cnts(0, 0, 0, 0);
    model_reset();
    idle(2);
    rst = 1'b0;
    idle(2);
    got.delete();
    send(2'b10, 8'h00);
    send(2'b00, 8'h5A);
    send(2'b01, 8'h00);
    settle();
    ew = {10'h200, 10'h05A, 10'h100};
    chk_words("post_rst_words");
    chk_cnts(1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
